rram_xbar_ctrl: RTL

//  Parametrised command-driven controller for the RRAM crossbar array. Drives WL/BL/WREN/RDEN/ADCSEL
//  and sequences column-muxed ADC reads. Adds a write-verify loop: pulse, read back, re-pulse only
//  the failing cells, up to MAX_RETRY times. Sits between the host command interface and the array.

---
 rtl/rram_xbar_if.sv | 36 +++
 rtl/rram_xbar_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/rram_xbar_if.sv
// Host-side command/response bundle for the RRAM crossbar controller.
// Array-side signals (WL/BL/ADC) stay as plain ports on the controller.
interface rram_xbar_if #(
  parameter int ROWS      = 1024,
  parameter int COLS      = 1024,
  parameter int NUM_ADCS  = 32,
  parameter int ADC_BITS  = 4,
  parameter int MAX_RETRY = 3
);
  localparam int MUX   = COLS / NUM_ADCS;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int GRP_W = (MUX > 1) ? $clog2(MUX) : 1;
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  logic                         cmd_valid;
  logic                         cmd_ready;
  logic                         cmd_op;
  logic [ROW_W-1:0]             cmd_row;
  logic [COLS-1:0]              cmd_data;
  logic                         rd_valid;
  logic [GRP_W-1:0]             rd_group;
  logic [NUM_ADCS*ADC_BITS-1:0] rd_data;
  logic                         rd_last;
  logic                         done;
  logic                         fail;
  logic [RTY_W-1:0]             retries;

  modport master (
    output cmd_valid, cmd_op, cmd_row, cmd_data,
    input  cmd_ready, rd_valid, rd_group, rd_data, rd_last, done, fail, retries
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_row, cmd_data,
    output cmd_ready, rd_valid, rd_group, rd_data, rd_last, done, fail, retries
  );
endinterface

// File: rtl/rram_xbar_ctrl.sv
// RRAM crossbar controller: row read via column-muxed ADC scan, and
// write-verify with selective re-pulse of cells that have not yet SET.
module rram_xbar_ctrl #(
  parameter int ROWS         = 1024,
  parameter int COLS         = 1024,
  parameter int NUM_ADCS     = 32,
  parameter int ADC_BITS     = 4,
  parameter int PULSE_CYCLES = 100,
  parameter int ADC_CYCLES   = 4,
  parameter int MAX_RETRY    = 3,
  parameter int SET_TH       = 8
) (
  input  logic                         CLK,
  input  logic                         RESET,
  rram_xbar_if.slave                   host,
  output logic [ROWS-1:0]              WL,
  output logic [COLS-1:0]              BL,
  output logic                         WREN,
  output logic                         RDEN,
  output logic [((COLS/NUM_ADCS) > 1 ? $clog2(COLS/NUM_ADCS) : 1)-1:0] ADCSEL,
  input  logic [NUM_ADCS*ADC_BITS-1:0] ADCout
);
  localparam int MUX     = COLS / NUM_ADCS;
  localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int GRP_W   = (MUX > 1) ? $clog2(MUX) : 1;
  localparam int RTY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int CNT_MAX = (PULSE_CYCLES > ADC_CYCLES) ? PULSE_CYCLES : ADC_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int DW      = NUM_ADCS * ADC_BITS;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_SCAN, S_RD_TAIL, S_WR_PULSE, S_WR_GAP, S_VFY_SCAN, S_EVAL, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COLS-1:0]  pend_q, pend_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [GRP_W-1:0] grp_q, grp_d;
  logic [RTY_W-1:0] rty_q, rty_d;
  logic             fail_q, fail_d;
  logic             rd_valid_q, rd_valid_d;
  logic             rd_last_q, rd_last_d;
  logic [GRP_W-1:0] rd_group_q, rd_group_d;
  logic [DW-1:0]    rd_data_q, rd_data_d;

  logic last_sub, last_grp;
  assign last_sub = (cnt_q == CW'(ADC_CYCLES - 1));
  assign last_grp = (grp_q == GRP_W'(MUX - 1));

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    pend_d     = pend_q;
    cnt_d      = cnt_q;
    grp_d      = grp_q;
    rty_d      = rty_q;
    fail_d     = fail_q;
    rd_valid_d = 1'b0;
    rd_last_d  = 1'b0;
    rd_group_d = rd_group_q;
    rd_data_d  = rd_data_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        grp_d = '0;
        if (host.cmd_valid) begin
          row_d   = host.cmd_row;
          rty_d   = '0;
          fail_d  = 1'b0;
          if (host.cmd_op) begin
            pend_d  = host.cmd_data;
            state_d = S_WR_PULSE;
          end else begin
            state_d = S_RD_SCAN;
          end
        end
      end
      S_RD_SCAN, S_VFY_SCAN: begin
        cnt_d = cnt_q + CW'(1);
        if (last_sub) begin
          cnt_d = '0;
          grp_d = grp_q + GRP_W'(1);
          if (state_q == S_RD_SCAN) begin
            rd_valid_d = 1'b1;
            rd_last_d  = last_grp;
            rd_group_d = grp_q;
            rd_data_d  = ADCout;
          end else begin
            // A pending cell that reads SET is retired; untargeted cells are already 0.
            for (int k = 0; k < NUM_ADCS; k++) begin
              if (int'(ADCout[k*ADC_BITS +: ADC_BITS]) >= SET_TH)
                pend_d[int'(grp_q)*NUM_ADCS + k] = 1'b0;
            end
          end
          if (last_grp) begin
            grp_d   = '0;
            state_d = (state_q == S_RD_SCAN) ? S_RD_TAIL : S_EVAL;
          end
        end
      end
      // Lets the registered rd_last strobe land one cycle ahead of done.
      S_RD_TAIL: state_d = S_DONE;
      S_WR_PULSE: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(PULSE_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_WR_GAP;
        end
      end
      S_WR_GAP: state_d = S_VFY_SCAN;
      S_EVAL: begin
        if (pend_q == '0) begin
          state_d = S_DONE;
        end else if (rty_q < RTY_W'(MAX_RETRY)) begin
          rty_d   = rty_q + RTY_W'(1);
          state_d = S_WR_PULSE;
        end else begin
          fail_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      pend_q     <= '0;
      cnt_q      <= '0;
      grp_q      <= '0;
      rty_q      <= '0;
      fail_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_group_q <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      grp_q      <= grp_d;
      rty_q      <= rty_d;
      fail_q     <= fail_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      rd_group_q <= rd_group_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Array drive is decoded straight from the state register so RESET clears it asynchronously.
  assign WREN   = (state_q == S_WR_PULSE);
  assign RDEN   = (state_q == S_RD_SCAN) || (state_q == S_VFY_SCAN);
  assign WL     = (WREN || RDEN) ? (ROWS'(1) << row_q) : '0;
  assign BL     = WREN ? pend_q : '0;
  assign ADCSEL = grp_q;

  assign host.cmd_ready = (state_q == S_IDLE);
  assign host.rd_valid  = rd_valid_q;
  assign host.rd_last   = rd_last_q;
  assign host.rd_group  = rd_group_q;
  assign host.rd_data   = rd_data_q;
  assign host.done      = (state_q == S_DONE);
  assign host.fail      = (state_q == S_DONE) && fail_q;
  assign host.retries   = rty_q;
endmodule
